// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared encodings for the control unit memory path
package cu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-port signals of the arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic          if_err;
  logic [31:0]   if_rdata;
  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ack;
  logic          d_err;
  logic [31:0]   d_rdata;
  logic          MFA;
  logic          mem_rw;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          MFC;

  // master: the arbiter itself; slave: control unit plus memory model
  modport master (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, MFC,
    output if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
           MFA, mem_rw, mem_size, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, MFC,
    input  if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
           MFA, mem_rw, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_align_check.sv
// rtl/mem_align_check.sv - flags accesses whose address is not aligned to their size
module mem_align_check
  import cu_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic       misaligned_o
);

  always_comb begin
    misaligned_o = 1'b0;
    case (size_i)
      SZ_HALF:           misaligned_o = addr_lo_i[0];
      SZ_WORD, SZ_DWORD: misaligned_o = |addr_lo_i;
      default:           misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the MFA/MFC memory port between fetch and data requesters
module mem_port_arbiter
  import cu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input logic                 Clk,
  input logic                 Reset,
  mem_port_arbiter_if.master  bus
);

  state_e        state_q;
  req_id_e       gnt_q;
  req_id_e       last_grant_q;
  logic [7:0]    cnt_q;
  logic          mfa_q;
  logic          rw_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          if_ack_q, if_err_q, d_ack_q, d_err_q;
  logic [31:0]   if_rdata_q, d_rdata_q;

  req_id_e       sel_d;
  logic [1:0]    size_d;
  logic [AW-1:0] addr_d;
  logic          rw_d;
  logic [31:0]   wdata_d;
  logic          misaligned;

  // Under contention the requester that did not win last time gets the port.
  always_comb begin
    sel_d   = REQ_IF;
    if (bus.d_req && (!bus.if_req || last_grant_q == REQ_IF)) sel_d = REQ_D;
    size_d  = SZ_WORD;
    addr_d  = bus.if_addr;
    rw_d    = 1'b0;
    wdata_d = '0;
    if (sel_d == REQ_D) begin
      size_d  = (bus.d_size == SZ_DWORD) ? SZ_WORD : bus.d_size;
      addr_d  = bus.d_addr;
      rw_d    = bus.d_we;
      wdata_d = bus.d_wdata;
    end
  end

  mem_align_check u_align (
    .size_i       (size_d),
    .addr_lo_i    (addr_d[1:0]),
    .misaligned_o (misaligned)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      gnt_q        <= REQ_IF;
      last_grant_q <= REQ_IF;
      cnt_q        <= '0;
      mfa_q        <= 1'b0;
      rw_q         <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      if_ack_q <= 1'b0;
      if_err_q <= 1'b0;
      d_ack_q  <= 1'b0;
      d_err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            gnt_q        <= sel_d;
            last_grant_q <= sel_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            rw_q         <= rw_d;
            wdata_q      <= wdata_d;
            if (misaligned) begin
              state_q <= DONE;
              if (sel_d == REQ_D) begin
                d_ack_q <= 1'b1;
                d_err_q <= 1'b1;
              end else begin
                if_ack_q <= 1'b1;
                if_err_q <= 1'b1;
              end
            end else begin
              state_q <= BUSY;
              mfa_q   <= 1'b1;
            end
          end
        end
        BUSY: begin
          // MFC takes priority over a timeout landing on the same cycle.
          if (bus.MFC) begin
            mfa_q   <= 1'b0;
            state_q <= DONE;
            if (gnt_q == REQ_D) begin
              d_ack_q <= 1'b1;
              if (!rw_q) d_rdata_q <= bus.mem_rdata;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            mfa_q   <= 1'b0;
            state_q <= DONE;
            if (gnt_q == REQ_D) begin
              d_ack_q <= 1'b1;
              d_err_q <= 1'b1;
            end else begin
              if_ack_q <= 1'b1;
              if_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.MFA       = mfa_q;
  assign bus.mem_rw    = rw_q;
  assign bus.mem_size  = size_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  mem_port_arbiter_if #(.AW(32)) bus ();

  mem_port_arbiter #(.TIMEOUT(4), .AW(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_if_rd = '0;
  logic [31:0] m_d_rd  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit is_d, input bit err);
    exp_t e;
    e.is_d  = is_d;
    e.err   = err;
    e.rdata = is_d ? m_d_rd : m_if_rd;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input bit is_d);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("unexpected ack", 32'(is_d) + 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("ack requester", 32'(is_d), 32'(e.is_d));
      chk("ack err", 32'(is_d ? bus.d_err : bus.if_err), 32'(e.err));
      chk("ack rdata", is_d ? bus.d_rdata : bus.if_rdata, e.rdata);
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.if_ack) pop_cmp(1'b0);
      if (bus.d_ack)  pop_cmp(1'b1);
    end
  end

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset   = 1'b0;
    m_if_rd = '0;
    m_d_rd  = '0;
  endtask

  // k: cycle whose edge samples MFC (0 = never); drop_c: cycle the request is withdrawn early
  task automatic do_txn(input bit is_d, input bit we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int k, input logic [31:0] rd, input int drop_c,
                        input int exp_mfa, input int exp_ack, input bit exp_err,
                        input logic [1:0] exp_msize);
    int c = 0;
    int mfa_n = 0;
    bit acked = 0;
    @(negedge Clk);
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_size = size;
      bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    bus.mem_rdata = rd;
    if (!exp_err && !we) begin
      if (is_d) m_d_rd = rd; else m_if_rd = rd;
    end
    push_exp(is_d, exp_err);
    while (!acked && c < 40) begin
      bus.MFC = (k > 0 && c == k);
      if (c == drop_c) begin bus.if_req = 1'b0; bus.d_req = 1'b0; end
      @(negedge Clk);
      if (bus.MFA) begin
        if (mfa_n == 0) begin
          chk("mem_addr", bus.mem_addr, addr);
          chk("mem_rw", 32'(bus.mem_rw), 32'(we));
          chk("mem_size", 32'(bus.mem_size), 32'(exp_msize));
          if (we) chk("mem_wdata", bus.mem_wdata, wdata);
        end
        mfa_n++;
      end
      if (bus.if_ack || bus.d_ack) begin
        acked = 1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
      end
      c++;
    end
    bus.MFC = 1'b0;
    chk("ack seen", 32'(acked), 32'd1);
    chk("MFA cycles", mfa_n, exp_mfa);
    chk("ack cycle", c, exp_ack);
  endtask

  initial begin
    int acks, cyc, last_ack;
    bit raise_if, raise_d;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_size = '0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.MFC = 0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset MFA", 32'(bus.MFA), 0);
    chk("reset acks", 32'({bus.if_ack, bus.d_ack, bus.if_err, bus.d_err}), 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset rdata", bus.if_rdata | bus.d_rdata, 0);

    do_txn(0, 0, 2'd2, 32'h10, 0, 3, 32'hA5A5A5A5, -1, 3, 4, 0, 2'd2);

    // both requests from reset, each re-raised once: D, IF, D, IF
    do_reset();
    bus.mem_rdata = 32'h11110000;
    m_if_rd = 32'h11110000;
    m_d_rd  = 32'h11110000;
    push_exp(1, 0); push_exp(0, 0); push_exp(1, 0); push_exp(0, 0);
    bus.d_we = 0; bus.d_size = 2'd2; bus.d_addr = 32'h80; bus.if_addr = 32'h90;
    bus.MFC = 1; bus.if_req = 1; bus.d_req = 1;
    acks = 0; cyc = 0; last_ack = -1; raise_if = 0; raise_d = 0;
    while (acks < 4 && cyc < 60) begin
      @(negedge Clk);
      cyc++;
      if (raise_if) begin bus.if_req = 1; raise_if = 0; end
      if (raise_d)  begin bus.d_req = 1;  raise_d = 0;  end
      if (bus.if_ack || bus.d_ack) begin
        acks++;
        if (last_ack >= 0) chk("ack spacing", cyc - last_ack, 3);
        else chk("first ack cycle", cyc, 2);
        last_ack = cyc;
        if (bus.if_ack) begin bus.if_req = 0; raise_if = (acks <= 2); end
        else begin bus.d_req = 0; raise_d = (acks <= 2); end
      end
    end
    bus.MFC = 0;
    chk("alternation acks", acks, 4);

    do_txn(1, 1, 2'd1, 32'h103, 32'hDEADBEEF, 0, 32'h0, -1, 0, 1, 1, 2'd1);
    do_txn(1, 1, 2'd1, 32'h102, 32'hDEADBEEF, 2, 32'h0, -1, 2, 3, 0, 2'd1);
    do_txn(0, 0, 2'd2, 32'h20, 0, 0, 32'h55555555, -1, 4, 5, 1, 2'd2);
    do_txn(0, 0, 2'd2, 32'h20, 0, 4, 32'h12345678, -1, 4, 5, 0, 2'd2);
    do_txn(1, 0, 2'd3, 32'h24, 0, 1, 32'h0BADF00D, -1, 1, 2, 0, 2'd2);
    do_txn(1, 0, 2'd0, 32'h07, 0, 2, 32'h00000077, -1, 2, 3, 0, 2'd0);

    // reset in the middle of a fetch: no ack, everything cleared
    @(negedge Clk);
    bus.if_req = 1; bus.if_addr = 32'h40;
    @(negedge Clk);
    chk("busy MFA", 32'(bus.MFA), 1);
    @(negedge Clk);
    Reset = 1;
    @(negedge Clk);
    chk("rst MFA", 32'(bus.MFA), 0);
    chk("rst acks", 32'({bus.if_ack, bus.d_ack}), 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst mem_size", 32'(bus.mem_size), 0);
    chk("rst rdata", bus.if_rdata | bus.d_rdata, 0);
    bus.if_req = 0; Reset = 0;
    m_if_rd = '0; m_d_rd = '0;
    do_txn(1, 0, 2'd2, 32'h44, 0, 1, 32'hCAFEF00D, -1, 1, 2, 0, 2'd2);

    // MFC in IDLE is ignored; a fetch withdrawn mid-BUSY still acks exactly once
    @(negedge Clk);
    bus.MFC = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("idle MFC no ack", 32'({bus.if_ack, bus.d_ack, bus.MFA}), 0);
    end
    bus.MFC = 0;
    do_txn(0, 0, 2'd2, 32'h30, 0, 3, 32'h9ABCDEF0, 1, 3, 4, 0, 2'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("no repeat ack", 32'({bus.if_ack, bus.d_ack}), 0);
    end

    chk("scoreboard drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single memory port (MFA/MFC handshake) between two requesters: instruction fetch (IF) and data load/store (D).
- Sits between the control unit and the memory model. The CU raises a request and waits for an ack instead of driving MFA and polling MFC itself.
- Adds misalignment detection, a bus timeout and fair alternation under contention.

Parameters:
- TIMEOUT, 16, max cycles MFA may stay high without MFC before abort (2..255).
- AW, 32, address width.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  AW  fetch address, word access.
- if_ack  out  1  one-cycle pulse, fetch finished.
- if_err  out  1  valid with if_ack: timeout or misaligned.
- if_rdata  out  32  fetched word, valid with if_ack.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  0 = byte, 1 = half, 2 = word, 3 = doubleword (treated as word, pair issued by CU).
- d_addr  in  AW  data address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle pulse, data op finished.
- d_err  out  1  valid with d_ack.
- d_rdata  out  32  load data, valid with d_ack.
- MFA  out  1  memory function active.
- mem_rw  out  1  1 = write.
- mem_size  out  2  access size to memory.
- mem_addr  out  AW  registered address.
- mem_wdata  out  32  registered store data.
- mem_rdata  in  32  memory read data.
- MFC  in  1  memory function complete.

Behaviour:
- Reset (sync, any state): state = IDLE. MFA, mem_rw, if_ack, d_ack, if_err and d_err all 0. mem_addr, mem_wdata, rdata outputs and mem_size cleared to 0. last_grant = IF (so D wins the first conflict). Timeout counter = 0.
- Reset during BUSY: MFA drops on the reset edge; the outstanding transaction produces no ack.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No requests: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the one not equal to last_grant.
  - On grant: latch addr, size, rw and wdata into the mem_* registers, record the granted requester, set last_grant.
- Alignment check, done in IDLE against the granted request:
  - Half needs addr[0] = 0. Word or doubleword needs addr[1:0] = 0. IF is always word-sized.
  - On misalignment: no memory access. Go directly to DONE with err = 1.
  - Otherwise go to BUSY. MFA = 1 on the cycle after the grant.
- BUSY:
  - MFA held at 1 and the timeout counter increments each cycle.
  - MFC = 1: capture mem_rdata into the granted requester's rdata register, MFA -> 0, go to DONE with err = 0.
  - Counter reaches TIMEOUT with no MFC: MFA -> 0, go to DONE with err = 1.
  - MFC sampled in the same cycle the counter reaches TIMEOUT: MFC wins (success).
- DONE:
  - Pulse the granted requester's ack for exactly one cycle; err is valid in that same cycle.
  - Clear the counter and return to IDLE.
  - A new grant is possible on the cycle after DONE, so there is a minimum one idle cycle between transactions. The requester must drop req on ack.
- Latency (req seen in IDLE at cycle 0, MFC first high at cycle k >= 1): MFA high over cycles 1..k, ack at cycle k+1. Misaligned: ack + err at cycle 1.
- Request dropped while its transaction is in BUSY: the transaction still completes and acks.
- A request line changing while not granted has no effect until the next IDLE evaluation.
- MFC high in IDLE or DONE is ignored.
- rdata registers hold their value until the next successful read by the same requester. Stores leave rdata unchanged.
- Byte and half load data is passed through unmodified; alignment/sign extension is the datapath's job.

Decomposition:
- Shared package (cu_pkg):
  - State encodings IDLE = 0, BUSY = 1, DONE = 2.
  - Size codes SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD.
  - Requester IDs REQ_IF, REQ_D.
- One sub-module, mem_align_check: combinational (size, addr[1:0]) -> misaligned. It is reused later by the trap logic for mem_address_not_aligned.

Test Plan:
- IF only, if_addr = 0x10, MFC high on the 3rd BUSY cycle with mem_rdata = 0xA5A5A5A5 -> MFA high cycles 1–3, if_ack at cycle 4 with if_rdata = 0xA5A5A5A5, if_err = 0.
- IF and D requested together from reset, then both re-requested -> D granted first, IF second, D third (alternation). Each pair of consecutive transactions is separated by at least one idle cycle.
- Store, d_size = 1, d_addr = 0x103 -> no MFA ever, d_ack with d_err = 1 at cycle 1. Repeat with d_addr = 0x102 -> MFA with mem_rw = 1, mem_size = 1, mem_wdata driven.
- MFC never asserted, TIMEOUT = 4 -> MFA high exactly 4 cycles, then ack with err = 1. Also MFC arriving exactly on the 4th cycle -> err = 0.
- Reset asserted during BUSY -> MFA = 0 and all outputs at reset values on the next edge, no ack. Next request serviced normally.
- MFC pulsed while IDLE, and if_req dropped mid-BUSY -> no spurious ack while IDLE. The dropped transaction still acks once after MFC.
